sys_cmd_ctrl: RTL and testbench
===============================

Name: sys_cmd_ctrl

Overview:
Parametrised command controller that sits between the UART RX/TX pair and the register file / ALU.
- Decodes RX frames into register-file writes and reads, plus ALU operations.
- After reset, writes two configuration registers.
- Returns read data and ALU results to UART TX over a valid/ready handshake.
- Flags unknown opcodes and response timeouts.

Parameters:
DATA_W, 8, frame / register-file data width
ADDR_W, 4, register-file address width (low ADDR_W bits of the address frame are used)
FUN_W, 4, ALU function width (low FUN_W bits of the function frame are used)
ALU_OUT_W, 16, ALU result width; must be an integer multiple of DATA_W
CFG0_ADDR, 2, first post-reset configuration address
CFG0_DATA, 8'h23, first post-reset configuration data
CFG1_ADDR, 3, second post-reset configuration address
CFG1_DATA, 8'h08, second post-reset configuration data
OP_WR, 8'hAA, opcode: write
OP_RD, 8'hBB, opcode: read
OP_ALU_OP, 8'hCC, opcode: ALU with operands
OP_ALU_NOP, 8'hDD, opcode: ALU without operands
TIMEOUT, 255, maximum cycles to wait for rd_valid / alu_valid

Ports:
clck  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  DATA_W  received frame
rx_valid  in  1  one-cycle strobe: rx_data valid
rd_data  in  DATA_W  register-file read data
rd_valid  in  1  rd_data valid
alu_out  in  ALU_OUT_W  ALU result
alu_valid  in  1  alu_out valid
tx_ready  in  1  TX can accept a byte
wr_en  out  1  register-file write strobe
rd_en  out  1  register-file read strobe
addr  out  ADDR_W  register-file address
wr_data  out  DATA_W  register-file write data
alu_fun  out  FUN_W  ALU function
alu_en  out  1  ALU start strobe
alu_clk_en  out  1  ALU clock-gate enable
tx_data  out  DATA_W  response byte
tx_valid  out  1  response byte valid
busy  out  1  high whenever the state is not IDLE
err  out  1  one-cycle error pulse

Behaviour:
- Outputs:
  - All outputs are registered.
  - While rst=1 all outputs are 0 and the state is CFG0.
- States and transitions:
  - CFG0 -> CFG1 -> IDLE, one cycle each, unconditional.
  - 1st edge after rst deasserts: wr_en=1, addr=CFG0_ADDR, wr_data=CFG0_DATA.
  - 2nd edge: wr_en=1, addr=CFG1_ADDR, wr_data=CFG1_DATA.
  - 3rd edge: wr_en=0; frames are accepted from then on.
- IDLE, on rx_valid:
  - OP_WR -> WR_ADDR; OP_RD -> RD_ADDR; OP_ALU_OP -> ALU_A; OP_ALU_NOP -> ALU_FUN.
  - Any other value: err=1 for one cycle, remain in IDLE.
- WR_ADDR: on rx_valid, latch addr -> WR_DATA.
- WR_DATA: on rx_valid, next cycle wr_en=1 for exactly one cycle with the latched addr and wr_data=rx_data -> IDLE.
- RD_ADDR: on rx_valid, next cycle rd_en=1 for one cycle with addr=rx_data[ADDR_W-1:0] -> RD_WAIT.
- RD_WAIT: on rd_valid, capture rd_data into the response buffer with count=1 -> TX_SEND.
- ALU_A: on rx_valid, one-cycle wr_en with addr=0, wr_data=rx_data -> ALU_B.
- ALU_B: same as ALU_A with addr=1 -> ALU_FUN.
- ALU_FUN: on rx_valid, alu_fun=rx_data[FUN_W-1:0] and one-cycle alu_en -> ALU_WAIT.
- ALU_WAIT: on alu_valid, capture alu_out with count=ALU_OUT_W/DATA_W -> TX_SEND.
- alu_clk_en:
  - High from the cycle alu_en asserts until alu_valid is captured (or timeout).
  - Low otherwise.
  - alu_fun holds its value until the next ALU command.
- TX_SEND:
  - Bytes are sent least-significant first; tx_valid is held with a stable tx_data until the cycle where tx_valid & tx_ready.
  - On that cycle the buffer shifts right by DATA_W and count decrements.
  - When the last byte transfers: tx_valid=0 next cycle -> IDLE.
- Timeout:
  - A counter runs in RD_WAIT and ALU_WAIT.
  - If TIMEOUT cycles elapse without the awaited valid: err=1 for one cycle, nothing is transmitted -> IDLE.
  - The counter clears on every entry to RD_WAIT / ALU_WAIT.
- Ignored and boundary cases:
  - rx_valid in RD_WAIT, ALU_WAIT, TX_SEND, CFG0 or CFG1 is dropped with no err.
  - rd_valid / alu_valid outside their wait states are ignored.
  - A simultaneous alu_valid and timeout expiry in the same cycle counts as success.
  - Unused upper bits of address and function frames are ignored.
  - Command frames have no inter-frame timeout: a partial command waits indefinitely.
- Reset mid-operation:
  - All outputs clear immediately.
  - Pending response and counters are discarded.
  - Configuration writes repeat after release.

Test Plan:
- Reset release, rx idle -> wr_en pulses at addr 2 / data 0x23, then at addr 3 / data 0x08, on consecutive edges; busy falls on the 3rd edge.
- rx 0xAA, 0x05, 0x5A -> single-cycle wr_en with addr=5, wr_data=0x5A; err=0; busy back to 0.
- rx 0xBB, 0x07; rd_valid with 0x3C after 3 cycles; tx_ready low for 2 cycles -> rd_en pulse with addr=7; tx_data=0x3C held until the handshake; exactly one byte sent.
- rx 0xCC, 0x10, 0x20, 0x02; alu_valid with alu_out=0x1234 -> wr_en addr0=0x10, then addr1=0x20; alu_fun=2 with alu_en pulse; tx bytes 0x34 then 0x12; alu_clk_en high only during the wait.
- rx 0xDD, 0x01 with no alu_valid -> err pulse after 255 cycles; no tx_valid; IDLE.
- rx 0x77 -> err pulse, state remains IDLE. Separately, assert rst during TX_SEND -> tx_valid=0 immediately; configuration writes repeat after release.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// Command controller between the UART RX/TX pair and the register file / ALU.
// Decodes command frames, runs post-reset configuration writes and returns responses over TX.
module sys_cmd_ctrl #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 4,
  parameter int                FUN_W      = 4,
  parameter int                ALU_OUT_W  = 16,
  parameter int                CFG0_ADDR  = 2,
  parameter logic [DATA_W-1:0] CFG0_DATA  = 8'h23,
  parameter int                CFG1_ADDR  = 3,
  parameter logic [DATA_W-1:0] CFG1_DATA  = 8'h08,
  parameter logic [DATA_W-1:0] OP_WR      = 8'hAA,
  parameter logic [DATA_W-1:0] OP_RD      = 8'hBB,
  parameter logic [DATA_W-1:0] OP_ALU_OP  = 8'hCC,
  parameter logic [DATA_W-1:0] OP_ALU_NOP = 8'hDD,
  parameter int                TIMEOUT    = 255
) (
  input  logic                 clck,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic                 rd_valid,
  input  logic [ALU_OUT_W-1:0] alu_out,
  input  logic                 alu_valid,
  input  logic                 tx_ready,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [FUN_W-1:0]     alu_fun,
  output logic                 alu_en,
  output logic                 alu_clk_en,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int NBYTES = ALU_OUT_W / DATA_W;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_CFG0,
    S_CFG1,
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_SEND
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr_lat, addr_lat_nxt;
  logic [ALU_OUT_W-1:0] resp_buf, resp_buf_nxt;
  logic [CNT_W-1:0]     byte_cnt, byte_cnt_nxt;
  logic [TMR_W-1:0]     tmr, tmr_nxt;
  logic                 timed_out;

  logic                 wr_en_nxt, rd_en_nxt, alu_en_nxt, alu_clk_en_nxt;
  logic                 tx_valid_nxt, busy_nxt, err_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [DATA_W-1:0]    wr_data_nxt, tx_data_nxt;
  logic [FUN_W-1:0]     alu_fun_nxt;

  // Last wait cycle: an awaited valid arriving now still wins over the timeout.
  assign timed_out = (tmr == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clck or posedge rst) begin
    if (rst) state <= S_CFG0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    addr_lat_nxt   = addr_lat;
    resp_buf_nxt   = resp_buf;
    byte_cnt_nxt   = byte_cnt;
    tmr_nxt        = tmr;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    alu_en_nxt     = 1'b0;
    err_nxt        = 1'b0;
    addr_nxt       = addr;
    wr_data_nxt    = wr_data;
    alu_fun_nxt    = alu_fun;
    alu_clk_en_nxt = alu_clk_en;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_valid;
    busy_nxt       = (state != S_IDLE);

    case (state)
      S_CFG0: begin
        wr_en_nxt   = 1'b1;
        addr_nxt    = ADDR_W'(CFG0_ADDR);
        wr_data_nxt = CFG0_DATA;
        state_nxt   = S_CFG1;
      end
      S_CFG1: begin
        wr_en_nxt   = 1'b1;
        addr_nxt    = ADDR_W'(CFG1_ADDR);
        wr_data_nxt = CFG1_DATA;
        state_nxt   = S_IDLE;
      end
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR)           state_nxt = S_WR_ADDR;
          else if (rx_data == OP_RD)      state_nxt = S_RD_ADDR;
          else if (rx_data == OP_ALU_OP)  state_nxt = S_ALU_A;
          else if (rx_data == OP_ALU_NOP) state_nxt = S_ALU_FUN;
          else                            err_nxt   = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (rx_valid) begin
          addr_lat_nxt = rx_data[ADDR_W-1:0];
          state_nxt    = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (rx_valid) begin
          wr_en_nxt   = 1'b1;
          addr_nxt    = addr_lat;
          wr_data_nxt = rx_data;
          state_nxt   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (rx_valid) begin
          rd_en_nxt = 1'b1;
          addr_nxt  = rx_data[ADDR_W-1:0];
          tmr_nxt   = '0;
          state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rd_valid) begin
          resp_buf_nxt = ALU_OUT_W'(rd_data);
          byte_cnt_nxt = CNT_W'(1);
          tx_data_nxt  = rd_data;
          tx_valid_nxt = 1'b1;
          state_nxt    = S_TX_SEND;
        end else if (timed_out) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      S_ALU_A: begin
        if (rx_valid) begin
          wr_en_nxt   = 1'b1;
          addr_nxt    = '0;
          wr_data_nxt = rx_data;
          state_nxt   = S_ALU_B;
        end
      end
      S_ALU_B: begin
        if (rx_valid) begin
          wr_en_nxt   = 1'b1;
          addr_nxt    = ADDR_W'(1);
          wr_data_nxt = rx_data;
          state_nxt   = S_ALU_FUN;
        end
      end
      S_ALU_FUN: begin
        if (rx_valid) begin
          alu_fun_nxt    = rx_data[FUN_W-1:0];
          alu_en_nxt     = 1'b1;
          alu_clk_en_nxt = 1'b1;
          tmr_nxt        = '0;
          state_nxt      = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (alu_valid) begin
          resp_buf_nxt   = alu_out;
          byte_cnt_nxt   = CNT_W'(NBYTES);
          tx_data_nxt    = alu_out[DATA_W-1:0];
          tx_valid_nxt   = 1'b1;
          alu_clk_en_nxt = 1'b0;
          state_nxt      = S_TX_SEND;
        end else if (timed_out) begin
          err_nxt        = 1'b1;
          alu_clk_en_nxt = 1'b0;
          state_nxt      = S_IDLE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      S_TX_SEND: begin
        // Least-significant byte leaves first; the next byte is presented right after each handshake.
        if (tx_valid && tx_ready) begin
          resp_buf_nxt = resp_buf >> DATA_W;
          byte_cnt_nxt = byte_cnt - CNT_W'(1);
          if (byte_cnt == CNT_W'(1)) begin
            tx_valid_nxt = 1'b0;
            state_nxt    = S_IDLE;
          end else begin
            tx_data_nxt = resp_buf_nxt[DATA_W-1:0];
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      addr_lat   <= '0;
      resp_buf   <= '0;
      byte_cnt   <= '0;
      tmr        <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      alu_clk_en <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      addr_lat   <= addr_lat_nxt;
      resp_buf   <= resp_buf_nxt;
      byte_cnt   <= byte_cnt_nxt;
      tmr        <= tmr_nxt;
      wr_en      <= wr_en_nxt;
      rd_en      <= rd_en_nxt;
      addr       <= addr_nxt;
      wr_data    <= wr_data_nxt;
      alu_fun    <= alu_fun_nxt;
      alu_en     <= alu_en_nxt;
      alu_clk_en <= alu_clk_en_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      busy       <= busy_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: directed scenarios plus random command traffic,
// checked against transaction queues built from the command semantics.
module tb_sys_cmd_ctrl;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int FUN_W     = 4;
  localparam int ALU_OUT_W = 16;
  localparam int TIMEOUT   = 255;
  localparam int NBYTES    = ALU_OUT_W / DATA_W;

  logic                 clck = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    rx_data;
  logic                 rx_valid;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_valid;
  logic [ALU_OUT_W-1:0] alu_out;
  logic                 alu_valid;
  logic                 tx_ready;
  logic                 wr_en, rd_en, alu_en, alu_clk_en, tx_valid, busy, err;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    wr_data, tx_data;
  logic [FUN_W-1:0]     alu_fun;

  sys_cmd_ctrl dut (
    .clck(clck), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .alu_out(alu_out), .alu_valid(alu_valid),
    .tx_ready(tx_ready),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .alu_fun(alu_fun), .alu_en(alu_en), .alu_clk_en(alu_clk_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .err(err)
  );

  always #5 clck = ~clck;

  int checks   = 0;
  int failures = 0;

  // Expected and observed transactions
  logic [ADDR_W+DATA_W-1:0] exp_wr[$], got_wr[$];
  logic [ADDR_W-1:0]        exp_rd[$], got_rd[$];
  logic [FUN_W-1:0]         exp_alu[$], got_alu[$];
  logic [DATA_W-1:0]        exp_tx[$], got_tx[$];
  int exp_err    = 0;
  int err_seen   = 0;
  int hold_viol  = 0;
  int hold_seen  = 0;
  int ready_mode = 2;
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // tx_ready: 0 = random, 1 = held low, 2 = held high
  always @(posedge clck) begin
    #1;
    case (ready_mode)
      1:       tx_ready = 1'b0;
      2:       tx_ready = 1'b1;
      default: tx_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor at the falling edge: outputs are settled and inputs hold what the next rising edge samples
  always @(negedge clck) begin
    if (rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (wr_en)  got_wr.push_back({addr, wr_data});
      if (rd_en)  got_rd.push_back(addr);
      if (alu_en) got_alu.push_back(alu_fun);
      if (err)    err_seen <= err_seen + 1;
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      if (hold_prev) begin
        hold_seen <= hold_seen + 1;
        if (!tx_valid || tx_data !== hold_data) hold_viol <= hold_viol + 1;
      end
      hold_prev <= tx_valid && !tx_ready;
      hold_data <= tx_data;
    end
  end

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic sendFrame(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Cycles in a wait state, with occasional frames that must be dropped
  task automatic waitWithJunk(input int n);
    repeat (n) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic waitTx();
    int n = 0;
    while (got_tx.size() < exp_tx.size() && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic waitErr();
    int n = 0;
    while (err_seen < exp_err && n < TIMEOUT + 20) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({wr_en, rd_en, addr, wr_data, alu_fun, alu_en, alu_clk_en, tx_data, tx_valid, busy, err});
  endfunction

  task automatic releaseAndCheckCfg();
    rst = 1'b0;
    tick();
    checkOutput("cfg0_write", {wr_en, busy, addr, wr_data}, {1'b1, 1'b1, 4'd2, 8'h23});
    exp_wr.push_back({4'd2, 8'h23});
    tick();
    checkOutput("cfg1_write", {wr_en, busy, addr, wr_data}, {1'b1, 1'b1, 4'd3, 8'h08});
    exp_wr.push_back({4'd3, 8'h08});
    tick();
    checkOutput("cfg_done", {wr_en, busy}, 2'b00);
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
    sendFrame(8'hAA); gap();
    sendFrame(a);     gap();
    sendFrame(d);
    checkOutput("wr_pulse", {wr_en, err, addr, wr_data}, {1'b1, 1'b0, a[3:0], d});
    exp_wr.push_back({a[3:0], d});
    tick();
    checkOutput("wr_single", wr_en, 1'b0);
    tick();
    checkOutput("wr_busy_idle", busy, 1'b0);
  endtask

  task automatic doRead(input logic [7:0] a, input logic [7:0] r, input int delay,
                        input bit drop, input int stall);
    int saved_mode = ready_mode;
    if (stall > 0) ready_mode = 1;
    sendFrame(8'hBB); gap();
    sendFrame(a);
    checkOutput("rd_pulse", {rd_en, addr}, {1'b1, a[3:0]});
    exp_rd.push_back(a[3:0]);
    waitWithJunk(delay);
    if (drop) begin
      exp_err++;
      waitErr();
      checkOutput("rd_timeout_no_tx", tx_valid, 1'b0);
    end else begin
      rd_data  = r;
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      rd_data  = 8'($urandom);
      exp_tx.push_back(r);
      repeat (stall) begin
        tick();
        checkOutput("tx_stall_data", {tx_valid, tx_data}, {1'b1, r});
      end
      ready_mode = saved_mode;
      waitTx();
    end
    ready_mode = saved_mode;
    repeat (2) tick();
  endtask

  task automatic doAlu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] f, input logic [15:0] v, input int delay, input bit drop);
    if (with_ops) begin
      sendFrame(8'hCC); gap();
      sendFrame(a);
      checkOutput("alu_opa_wr", {wr_en, addr, wr_data}, {1'b1, 4'd0, a});
      exp_wr.push_back({4'd0, a});
      gap();
      sendFrame(b);
      checkOutput("alu_opb_wr", {wr_en, addr, wr_data}, {1'b1, 4'd1, b});
      exp_wr.push_back({4'd1, b});
      gap();
    end else begin
      sendFrame(8'hDD); gap();
    end
    sendFrame(f);
    checkOutput("alu_start", {alu_en, alu_clk_en, alu_fun}, {1'b1, 1'b1, f[3:0]});
    exp_alu.push_back(f[3:0]);
    waitWithJunk(delay);
    checkOutput("alu_clk_en_wait", alu_clk_en, 1'b1);
    if (drop) begin
      exp_err++;
      waitErr();
      checkOutput("alu_timeout_clk_off", {alu_clk_en, tx_valid}, 2'b00);
    end else begin
      alu_out   = v;
      alu_valid = 1'b1;
      tick();
      alu_valid = 1'b0;
      alu_out   = 16'($urandom);
      checkOutput("alu_clk_en_off", alu_clk_en, 1'b0);
      for (int i = 0; i < NBYTES; i++) exp_tx.push_back(v[i*8 +: 8]);
      waitTx();
    end
    repeat (2) tick();
  endtask

  task automatic doBadOp();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
    sendFrame(b);
    checkOutput("badop_err", {err, busy}, 2'b10);
    exp_err++;
    tick();
    checkOutput("badop_err_single", {err, busy}, 2'b00);
  endtask

  // One randomized command, preceded sometimes by stray valids that an idle controller ignores
  task automatic applyStimulus();
    int kind = $urandom_range(0, 8);
    bit drop = ($urandom_range(0, 11) == 0);
    if ($urandom_range(0, 3) == 0) begin
      rd_valid  = 1'b1;
      alu_valid = 1'b1;
      tick();
      rd_valid  = 1'b0;
      alu_valid = 1'b0;
    end
    case (kind)
      0, 1:    doWrite(8'($urandom), 8'($urandom));
      2, 3:    doRead(8'($urandom), 8'($urandom), $urandom_range(0, 5), drop, 0);
      4, 5:    doAlu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                     $urandom_range(0, 5), drop);
      6, 7:    doAlu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom), $urandom_range(0, 5), drop);
      default: doBadOp();
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  saw_tx;
    rst       = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rd_data   = '0;
    rd_valid  = 1'b0;
    alu_out   = '0;
    alu_valid = 1'b0;

    repeat (3) tick();
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    releaseAndCheckCfg();

    doWrite(8'h05, 8'h5A);
    doRead(8'h07, 8'h3C, 3, 1'b0, 2);
    doAlu(1'b1, 8'h10, 8'h20, 8'h02, 16'h1234, 3, 1'b0);

    // Full timeout with no alu_valid: err exactly TIMEOUT cycles after the start strobe
    sendFrame(8'hDD);
    sendFrame(8'h01);
    exp_alu.push_back(4'h1);
    exp_err++;
    n      = 0;
    saw_tx = 1'b0;
    while (!err && n < TIMEOUT + 50) begin
      tick();
      n++;
      if (tx_valid) saw_tx = 1'b1;
    end
    checkOutput("timeout_cycles", n, TIMEOUT);
    checkOutput("timeout_no_tx", {saw_tx, alu_clk_en}, 2'b00);
    repeat (2) tick();
    checkOutput("timeout_idle", busy, 1'b0);

    // alu_valid on the very cycle the timeout expires is a success
    doAlu(1'b0, 8'h00, 8'h00, 8'hF5, 16'hBEEF, TIMEOUT - 1, 1'b0);

    sendFrame(8'h77);
    checkOutput("op77_err", {err, busy}, 2'b10);
    exp_err++;
    tick();

    ready_mode = 0;
    repeat (40) applyStimulus();

    // Reset while a response byte is waiting for tx_ready
    ready_mode = 1;
    repeat (2) tick();
    sendFrame(8'hBB);
    sendFrame(8'h09);
    exp_rd.push_back(4'h9);
    rd_data  = 8'hA5;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    tick();
    checkOutput("tx_before_reset", {tx_valid, tx_data}, {1'b1, 8'hA5});
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_tx", allOutputs(), 32'd0);
    repeat (2) tick();
    ready_mode = 2;
    releaseAndCheckCfg();
    repeat (3) tick();
    checkOutput("post_reset_no_tx", tx_valid, 1'b0);

    checkOutput("wr_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      checkOutput("wr_event", got_wr[i], exp_wr[i]);
    checkOutput("rd_count", got_rd.size(), exp_rd.size());
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      checkOutput("rd_event", got_rd[i], exp_rd[i]);
    checkOutput("alu_count", got_alu.size(), exp_alu.size());
    for (int i = 0; i < got_alu.size() && i < exp_alu.size(); i++)
      checkOutput("alu_event", got_alu[i], exp_alu[i]);
    checkOutput("tx_count", got_tx.size(), exp_tx.size());
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      checkOutput("tx_byte", got_tx[i], exp_tx[i]);
    checkOutput("err_count", err_seen, exp_err);
    checkOutput("tx_hold_stable", hold_viol, 0);
    checkOutput("tx_hold_seen", (hold_seen > 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
